pair_frame_writer: RTL and testbench



---
 rtl/pair_frame_writer_if.sv | 34 +++
 rtl/pair_frame_writer.sv | 145 ++++++++++++++
 tb/tb_pair_frame_writer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pair_frame_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : pair_frame_writer_if
// Description : Producer-side pixel-pair stream plus frame-buffer write port
//               of the pair frame writer, bundled as one interface.
// Revision    : 1.0 - initial release
// ============================================================================
interface pair_frame_writer_if #(
  parameter int ADDR_W = 19
);
  logic              in_valid;
  logic [35:0]       in_pair;
  logic              in_sof;
  logic              in_ready;
  logic              wr_grant;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [35:0]       mem_data;
  logic              frame_done;
  logic              overflow;

  // Drives pixel pairs and write grants; observes the write port.
  modport master (
    output in_valid, in_pair, in_sof, wr_grant,
    input  in_ready, mem_we, mem_addr, mem_data, frame_done, overflow
  );

  // The frame writer itself.
  modport slave (
    input  in_valid, in_pair, in_sof, wr_grant,
    output in_ready, mem_we, mem_addr, mem_data, frame_done, overflow
  );
endinterface
`default_nettype wire

// File: rtl/pair_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : pair_frame_writer
// Description : Buffers 36-bit pixel-pair words in a small FIFO and writes
//               them to the ZBT frame buffer on arbiter grants, at sequential
//               frame-aligned word addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module pair_frame_writer #(
  parameter int ADDR_W      = 19,
  parameter int DEPTH       = 4,
  parameter int FRAME_WORDS = 153600,
  parameter int BASE_ADDR   = 0
) (
  input  wire logic          clk,
  input  wire logic          reset,
  pair_frame_writer_if.slave bus
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;

  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0]  c_BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]  c_LAST  = ADDR_W'(BASE_ADDR + FRAME_WORDS - 1);

  localparam logic [0:0] S_SYNC = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_next;
  logic               w_in_ready;

  logic [36:0]        r_fifo [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic [36:0]        w_head;
  logic [ADDR_W-1:0]  w_issue_addr;

  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [35:0]        r_mem_data;
  logic               r_frame_done;
  logic               r_overflow;
  logic [ADDR_W-1:0]  r_addr_cnt;

  // In SYNC only a start-of-frame word is kept; in RUN every accepted word is.
  // Pops look only at the registered count, so a word pushed this cycle can
  // never be written on the same grant.
  assign w_push = bus.in_valid & w_in_ready & ((r_state == S_RUN) | bus.in_sof);
  assign w_pop  = bus.wr_grant & (r_count != '0);
  assign w_drop = bus.in_valid & ~w_in_ready & (r_state == S_RUN);

  // A start-of-frame word always lands at the frame base, resyncing the count.
  assign w_head       = r_fifo[r_rd_ptr];
  assign w_issue_addr = w_head[36] ? c_BASE : r_addr_cnt;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: leave SYNC on the first valid start-of-frame word.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_SYNC:  if (bus.in_valid && bus.in_sof) w_state_next = S_RUN;
      S_RUN:   w_state_next = S_RUN;
      default: w_state_next = S_SYNC;
    endcase
  end

  // FSM outputs: ready depends only on state and registered occupancy.
  always_comb begin
    w_in_ready = 1'b1;
    case (r_state)
      S_SYNC:  w_in_ready = 1'b1;
      S_RUN:   w_in_ready = (r_count < c_DEPTH);
      default: w_in_ready = 1'b1;
    endcase
  end

  // FIFO storage: {sof, pair} per entry; contents are don't-care when empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {bus.in_sof, bus.in_pair};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Write port, frame address counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_we     <= 1'b0;
      r_mem_addr   <= c_BASE;
      r_mem_data   <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_addr_cnt   <= c_BASE;
    end else begin
      r_mem_we     <= w_pop;
      r_frame_done <= w_pop & (w_issue_addr == c_LAST);
      if (w_pop) begin
        r_mem_addr <= w_issue_addr;
        r_mem_data <= w_head[35:0];
        r_addr_cnt <= (w_issue_addr == c_LAST) ? c_BASE : w_issue_addr + 1'b1;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_data   = r_mem_data;
  assign bus.frame_done = r_frame_done;
  assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pair_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pair_frame_writer
// Description : Directed self-checking bench for pair_frame_writer, built
//               with an 8-word frame so that wrap and resync are reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pair_frame_writer;

  localparam int c_ADDR_W = 19;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  pair_frame_writer_if #(.ADDR_W(c_ADDR_W)) bus ();

  pair_frame_writer #(
    .ADDR_W     (c_ADDR_W),
    .DEPTH      (4),
    .FRAME_WORDS(8),
    .BASE_ADDR  (0)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and log mismatches.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Apply one cycle of inputs; return 1 time unit after the edge.
  task automatic step(input logic v, input logic [35:0] p, input logic s, input logic g);
    bus.in_valid = v;
    bus.in_pair  = p;
    bus.in_sof   = s;
    bus.wr_grant = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  // Check an expected write on the cycle just completed.
  task automatic check_wr(input string tag, input int addr, input logic [35:0] data, input logic fd);
    check({tag, "_we"},   64'(bus.mem_we),     64'd1);
    check({tag, "_addr"}, 64'(bus.mem_addr),   64'(addr));
    check({tag, "_data"}, 64'(bus.mem_data),   64'(data));
    check({tag, "_fd"},   64'(bus.frame_done), 64'(fd));
  endtask

  function automatic logic [35:0] word(input int i);
    logic [17:0] hi;
    logic [17:0] lo;
    hi = 18'(i * 3 + 1);
    lo = 18'(i * 7 + 5);
    return {hi, lo};
  endfunction

  int exp_addr5 [8] = '{0, 1, 2, 3, 4, 0, 1, 2};

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_pair  = '0;
    bus.in_sof   = 1'b0;
    bus.wr_grant = 1'b0;

    // Reset state.
    step(1'b0, '0, 1'b0, 1'b0);
    do_reset();
    check("rst_we",    64'(bus.mem_we),     64'd0);
    check("rst_addr",  64'(bus.mem_addr),   64'd0);
    check("rst_data",  64'(bus.mem_data),   64'd0);
    check("rst_fd",    64'(bus.frame_done), 64'd0);
    check("rst_ovf",   64'(bus.overflow),   64'd0);
    check("rst_ready", 64'(bus.in_ready),   64'd1);

    // Four words, grant held: each write one cycle after its grant.
    step(1'b1, word(0), 1'b1, 1'b1);
    check("t1_nofall", 64'(bus.mem_we), 64'd0);
    for (int k = 1; k < 4; k++) begin
      step(1'b1, word(k), 1'b0, 1'b1);
      check_wr($sformatf("t1_w%0d", k - 1), k - 1, word(k - 1), 1'b0);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    check_wr("t1_w3", 3, word(3), 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("t1_idle_we",   64'(bus.mem_we),   64'd0);
    check("t1_hold_addr", 64'(bus.mem_addr), 64'd3);
    check("t1_hold_data", 64'(bus.mem_data), 64'(word(3)));

    // SYNC discards non-sof words; only the sof word is written at base.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, word(10 + k), 1'b0, 1'b1);
      check($sformatf("t2_disc%0d", k), 64'(bus.mem_we), 64'd0);
    end
    step(1'b1, word(13), 1'b1, 1'b1);
    check("t2_nofall", 64'(bus.mem_we), 64'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    check_wr("t2_a", 0, word(13), 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("t2_empty_we", 64'(bus.mem_we),   64'd0);
    check("t2_ovf",      64'(bus.overflow), 64'd0);

    // Alternate grants, producer every cycle: FIFO fills, then a forced drop.
    for (int k = 1; k <= 7; k++) begin
      step(1'b1, word(20 + k), 1'b0, (k % 2) == 0);
      if ((k % 2) == 0) check_wr($sformatf("t3_w%0d", k), k / 2, word(20 + k / 2), 1'b0);
      else              check($sformatf("t3_idle%0d", k), 64'(bus.mem_we), 64'd0);
      if (k == 6) check("t3_ready_3", 64'(bus.in_ready), 64'd1);
      if (k == 7) check("t3_ready_4", 64'(bus.in_ready), 64'd0);
    end
    check("t3_ovf_pre", 64'(bus.overflow), 64'd0);
    step(1'b1, word(28), 1'b0, 1'b1);
    check_wr("t3_w8", 4, word(24), 1'b0);
    check("t3_ovf_set", 64'(bus.overflow), 64'd1);
    for (int k = 5; k <= 7; k++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      check_wr($sformatf("t3_drain%0d", k), k, word(20 + k), k == 7);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    check("t3_nodrop_we", 64'(bus.mem_we),     64'd0);
    check("t3_fd_clr",    64'(bus.frame_done), 64'd0);
    check("t3_ovf_stick", 64'(bus.overflow),   64'd1);

    // Full frame of 8 then a sof word: frame_done on address 7, wrap to 0.
    do_reset();
    check("t4_ovf_rst", 64'(bus.overflow), 64'd0);
    for (int k = 0; k <= 8; k++) begin
      step(1'b1, word(40 + k), (k == 0) || (k == 8), 1'b1);
      if (k >= 1) check_wr($sformatf("t4_w%0d", k - 1), k - 1, word(40 + k - 1), (k - 1) == 7);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    check_wr("t4_sof", 0, word(48), 1'b0);

    // Mid-frame sof after 5 words resyncs to base without frame_done.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, word(60 + k), (k == 0) || (k == 5), 1'b1);
      if (k >= 1) check_wr($sformatf("t5_w%0d", k - 1), exp_addr5[k - 1], word(60 + k - 1), 1'b0);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    check_wr("t5_w7", exp_addr5[7], word(67), 1'b0);

    // Reset with three words queued: nothing stale is written afterwards.
    do_reset();
    step(1'b1, word(80), 1'b1, 1'b0);
    step(1'b1, word(81), 1'b0, 1'b0);
    step(1'b1, word(82), 1'b0, 1'b0);
    check("t6_q_we",    64'(bus.mem_we),   64'd0);
    check("t6_q_ready", 64'(bus.in_ready), 64'd1);
    reset = 1'b1;
    step(1'b0, '0, 1'b0, 1'b1);
    reset = 1'b0;
    check("t6_rst_we",    64'(bus.mem_we),   64'd0);
    check("t6_rst_ready", 64'(bus.in_ready), 64'd1);
    check("t6_rst_addr",  64'(bus.mem_addr), 64'd0);
    check("t6_rst_data",  64'(bus.mem_data), 64'd0);
    step(1'b0, '0, 1'b1, 1'b1);
    check("t6_sof_novalid", 64'(bus.mem_we), 64'd0);
    step(1'b1, word(90), 1'b0, 1'b1);
    check("t6_sync_disc", 64'(bus.mem_we), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      check($sformatf("t6_stale%0d", k), 64'(bus.mem_we), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
